alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_issue_stage.sv | 91 +++++++++
 tb/tb_alu_issue_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and default widths for the ALU issue/capture stage.
// Pure declarations; no logic.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] OP_PASS_A = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_ADD    = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_SUB    = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_AND    = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_OR     = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_INC    = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_DEC    = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_PASS_B = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_stage.sv
// Issue/capture stage: registers a command onto the external ALU, captures its result one cycle later.
// Latency: result valid the cycle after the EXEC cycle; one result per 2 cycles when never stalled.
// Backpressure: a stalled result (res_ready=0) holds everything and drops cmd_ready. ALU_ISSUE_FLAGS_EN adds res_zero/res_neg.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [OPW-1:0]   alu_op_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic             res_zero,
    output logic             res_neg
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic             cmd_fire;

    assign cmd_fire = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = EXEC;
            end
            EXEC: state_d = DONE;
            DONE: begin
                // Accepting the result and a new command in the same cycle keeps the 2-cycle cadence.
                cmd_ready = res_ready;
                if (res_ready) state_d = cmd_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_op_code <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            acc_q       <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            res_zero    <= 1'b0;
            res_neg     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                alu_op_code <= cmd_op;
                alu_a       <= cmd_use_acc ? acc_q : cmd_a;
                alu_b       <= cmd_b;
            end
            if (state_q == EXEC) begin
                res_data  <= alu_y;
                acc_q     <= alu_y;
                res_valid <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                res_zero  <= (alu_y == '0);
                res_neg   <= alu_y[WIDTH-1];
`endif
            end else if (state_q == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a transaction-level reference model and a per-cycle compare.
module tb_alu_issue_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          cmd_use_acc;
    logic [2:0]    alu_op_code;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_y;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
`ifdef ALU_ISSUE_FLAGS_EN
    logic          res_zero;
    logic          res_neg;
`endif

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(W), .OPW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_op_code (alu_op_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .res_zero    (res_zero),
        .res_neg     (res_neg)
`endif
    );

    // The 8-op ALU the parent would instantiate.
    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a + 1;
            3'd6:    return a - 1;
            default: return b;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_op_code, alu_a, alu_b);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an op in flight, a held result, and the last-result accumulator.
    bit           m_flight, m_held;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b, m_res, m_acc;
    logic [W-1:0] log_data[$];
    int           log_cyc[$];

    function automatic bit exp_ready();
        return !m_flight && (!m_held || res_ready);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_flight = 0; m_held = 0;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_acc = '0;
        end else begin
            bit take;
            take = exp_ready() && cmd_valid;
            if (m_flight) begin
                m_res    = alu_fn(m_op, m_a, m_b);
                m_acc    = m_res;
                m_held   = 1;
                m_flight = 0;
            end else if (m_held && res_ready) begin
                log_data.push_back(m_res);
                log_cyc.push_back(cyc);
                m_held = 0;
            end
            if (take) begin
                m_op     = cmd_op;
                m_a      = cmd_use_acc ? m_acc : cmd_a;
                m_b      = cmd_b;
                m_flight = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready()});
            chk("res_valid", {31'd0, res_valid}, {31'd0, m_held});
            chk("res_data", res_data, m_res);
            chk("alu_op_code", {29'd0, alu_op_code}, {29'd0, m_op});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
`ifdef ALU_ISSUE_FLAGS_EN
            if (m_held) begin
                chk("res_zero", {31'd0, res_zero}, {31'd0, (m_res == '0)});
                chk("res_neg", {31'd0, res_neg}, {31'd0, m_res[W-1]});
            end
`endif
        end
    end

    // Leaves cmd_valid asserted; returns 2 time units after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ua);
        bit ok;
        ok = 0;
        cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=no_accept required=accept (cycle %0d)", cyc);
        end
        #2;
    endtask

    task automatic drain();
        cmd_valid = 0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_log[16];
        bit seen;
        exp_log = '{32'd12, 32'd13, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0, 32'h77, 32'hFF,
                    32'h10, 32'h13, 32'hD, 32'h0, 32'h13, 32'h11, 32'hF, 32'h3, 32'h4};

        rst = 1; cmd_valid = 0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 0; res_ready = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        started = 1;
        @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #2;

        // Basic add, with first-result timing.
        issue(3'b001, 32'd5, 32'd7, 0);
        cmd_valid = 0;
        @(negedge clk);
        chk("add_exec_opcode", {29'd0, alu_op_code}, 32'd1);
        chk("add_exec_no_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_data", res_data, 32'd12);
        drain();

        // Chaining through the accumulator.
        issue(3'b101, 32'hDEAD, 32'd0, 1);
        cmd_valid = 0;
        @(negedge clk);
        chk("chain_alu_a", alu_a, 32'd12);
        drain();
        issue(3'b010, 32'd0, 32'd20, 1);
        drain();

        // Wrap-around.
        issue(3'b010, 32'd0, 32'd1, 0);
        drain();
        issue(3'b001, 32'hFFFF_FFFF, 32'd1, 0);
        cmd_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("wrap_zero_data", res_data, 32'd0);
`ifdef ALU_ISSUE_FLAGS_EN
        chk("wrap_res_zero", {31'd0, res_zero}, 32'd1);
`endif
        drain();

        // Backpressure with a pending command.
        res_ready = 0;
        issue(3'b000, 32'h77, 32'd0, 0);
        cmd_op = 3'b100; cmd_a = 32'hF0; cmd_b = 32'h0F; cmd_use_acc = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("bp_result_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_res_data", res_data, 32'h77);
            chk("bp_alu_op_code", {29'd0, alu_op_code}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #2 res_ready = 1;
        @(posedge clk); #2 cmd_valid = 0;
        @(negedge clk);
        chk("bp_exec_opcode", {29'd0, alu_op_code}, 32'd4);
        @(negedge clk);
        chk("bp_or_valid", {31'd0, res_valid}, 32'd1);
        chk("bp_or_data", res_data, 32'hFF);
        drain();

        // Back-to-back, all opcodes.
        for (int i = 0; i < 8; i++) issue(3'(i), 32'h10, 32'h3, 0);
        drain();

        // Reset while an op is executing.
        issue(3'b001, 32'd1, 32'd1, 0);
        cmd_valid = 0; rst = 1;
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mid_data", res_data, 32'd0);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #2;
        issue(3'b001, 32'hABC, 32'd4, 1);
        drain();

        chk("result_count", 32'(log_data.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_data.size(); i++)
            chk($sformatf("result_%0d", i), log_data[i], exp_log[i]);
        for (int i = 8; i < 15 && i < log_cyc.size(); i++)
            chk($sformatf("b2b_spacing_%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);

        started = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
